aurora_link_supervisor: RTL

Autonomous bring-up and recovery controller for the Aurora chip-to-chip link. Drives the Aurora reset_pb and pma_init inputs through the required timed sequence, waits for channel_up with a timeout, and retries on failure. Once the link is up, it watches for sustained channel_up loss and re-runs the sequence. Sits between the board/software reset request and the Aurora core, and reports link status to the register block.

---
 rtl/aurora_link_supervisor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/aurora_link_supervisor.sv
// Bring-up and recovery sequencer for an Aurora link: times reset_pb / pma_init,
// waits for channel_up with a timeout, retries, and re-runs after sustained link loss.
module aurora_link_supervisor #(
  parameter int unsigned PB_LEAD_CYCLES  = 128,
  parameter int unsigned PMA_HOLD_CYCLES = 1000000,
  parameter int unsigned PB_TRAIL_CYCLES = 10000,
  parameter int unsigned LINKUP_TIMEOUT  = 50000000,
  parameter int unsigned DOWN_DEBOUNCE   = 1000,
  parameter int unsigned MAX_RETRIES     = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        reset_req,
  input  logic        channel_up,
  output logic        reset_pb_out,
  output logic        pma_init_out,
  output logic        link_up,
  output logic        link_failed,
  output logic [7:0]  retry_count,
  output logic [15:0] link_drops,
  output logic [2:0]  state_out
);

  // Counter load values: a duration of N loads N-1; zero durations behave as one cycle.
  localparam logic [31:0] LD_PB_LEAD = (PB_LEAD_CYCLES  == 0) ? 32'd0 : 32'(PB_LEAD_CYCLES  - 1);
  localparam logic [31:0] LD_PMA     = (PMA_HOLD_CYCLES == 0) ? 32'd0 : 32'(PMA_HOLD_CYCLES - 1);
  localparam logic [31:0] LD_TRAIL   = (PB_TRAIL_CYCLES == 0) ? 32'd0 : 32'(PB_TRAIL_CYCLES - 1);
  localparam logic [31:0] LD_TIMEOUT = (LINKUP_TIMEOUT  == 0) ? 32'd0 : 32'(LINKUP_TIMEOUT  - 1);
  localparam logic [31:0] LD_DEB     = (DOWN_DEBOUNCE   == 0) ? 32'd0 : 32'(DOWN_DEBOUNCE   - 1);

  typedef enum logic [2:0] {
    S_PB_LEAD = 3'd0,
    S_PMA     = 3'd1,
    S_TRAIL   = 3'd2,
    S_WAIT_UP = 3'd3,
    S_UP      = 3'd4,
    S_FAILED  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_sync1;
  logic        r_ch_up_s;
  logic        r_pb;
  logic        r_pma;
  logic        r_link_up;
  logic        r_failed;
  logic [7:0]  r_retry;
  logic [15:0] r_drops;

  logic        w_cnt_zero;
  logic [7:0]  w_retry_inc;
  logic        w_retry_limit;

  assign w_cnt_zero    = (r_cnt == 32'd0);
  assign w_retry_inc   = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;
  assign w_retry_limit = (MAX_RETRIES != 0) && (32'(w_retry_inc) >= MAX_RETRIES);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync1   <= 1'b0;
      r_ch_up_s <= 1'b0;
    end else begin
      r_sync1   <= channel_up;
      r_ch_up_s <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_PB_LEAD;
      r_cnt     <= LD_PB_LEAD;
      r_pb      <= 1'b1;
      r_pma     <= 1'b0;
      r_link_up <= 1'b0;
      r_failed  <= 1'b0;
      r_retry   <= 8'd0;
      r_drops   <= 16'd0;
    end else if (reset_req) begin
      r_state   <= S_PB_LEAD;
      r_cnt     <= LD_PB_LEAD;
      r_pb      <= 1'b1;
      r_pma     <= 1'b0;
      r_link_up <= 1'b0;
      r_failed  <= 1'b0;
      r_retry   <= 8'd0;
    end else begin
      case (r_state)
        S_PB_LEAD: begin
          if (w_cnt_zero) begin
            r_state <= S_PMA;
            r_cnt   <= LD_PMA;
            r_pma   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_PMA: begin
          if (w_cnt_zero) begin
            r_state <= S_TRAIL;
            r_cnt   <= LD_TRAIL;
            r_pma   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_TRAIL: begin
          if (w_cnt_zero) begin
            r_state <= S_WAIT_UP;
            r_cnt   <= LD_TIMEOUT;
            r_pb    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_WAIT_UP: begin
          // A link arriving on the timeout cycle still counts as success.
          if (r_ch_up_s) begin
            r_state   <= S_UP;
            r_cnt     <= LD_DEB;
            r_link_up <= 1'b1;
            r_retry   <= 8'd0;
          end else if (w_cnt_zero) begin
            r_retry <= w_retry_inc;
            r_pb    <= 1'b1;
            if (w_retry_limit) begin
              r_state  <= S_FAILED;
              r_failed <= 1'b1;
            end else begin
              r_state <= S_PB_LEAD;
              r_cnt   <= LD_PB_LEAD;
            end
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_UP: begin
          // The shared counter doubles as the debounce run length while up.
          if (r_ch_up_s) begin
            r_cnt <= LD_DEB;
          end else if (w_cnt_zero) begin
            r_state   <= S_PB_LEAD;
            r_cnt     <= LD_PB_LEAD;
            r_pb      <= 1'b1;
            r_link_up <= 1'b0;
            r_drops   <= (r_drops == 16'hFFFF) ? 16'hFFFF : r_drops + 16'd1;
          end else begin
            r_cnt <= r_cnt - 32'd1;
          end
        end
        S_FAILED: begin
          r_pb     <= 1'b1;
          r_pma    <= 1'b0;
          r_failed <= 1'b1;
        end
        default: begin
          r_state   <= S_PB_LEAD;
          r_cnt     <= LD_PB_LEAD;
          r_pb      <= 1'b1;
          r_pma     <= 1'b0;
          r_link_up <= 1'b0;
          r_failed  <= 1'b0;
        end
      endcase
    end
  end

  assign reset_pb_out = r_pb;
  assign pma_init_out = r_pma;
  assign link_up      = r_link_up;
  assign link_failed  = r_failed;
  assign retry_count  = r_retry;
  assign link_drops   = r_drops;
  assign state_out    = r_state;

endmodule
